// File: rtl/sram_ctrl_param.sv
// SRAM controller for the MEM stage: configurable wait states, multi-word read bursts, single-word writes.
// Latency: read ready after BURST_LEN*(WAIT_CYCLES+1)+1 cycles, write ready after WAIT_CYCLES+2 cycles.
// Backpressure: ready is low while a transaction is in flight; the requester holds its request until ready.
module sram_ctrl_param #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 19,
    parameter int WAIT_CYCLES = 3,
    parameter int BURST_LEN   = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [31:0]                   address,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W*BURST_LEN-1:0]   rdata,
    output logic                          ready,
    inout  wire  [DATA_W-1:0]             SRAM_DQ,
    output logic [ADDR_W-1:0]             SRAM_Addr,
    output logic                          SRAM_WE_N
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic                       op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;
    logic [1:0]                 word_q, word_d;
    logic [3:0]                 wait_q, wait_d;
    logic [DATA_W*BURST_LEN-1:0] rdata_q, rdata_d;
    logic                       we_n_q, we_n_d;

    logic [31:0]       byte_off;
    logic [ADDR_W-1:0] word_addr;
    logic              last_wait;
    logic              last_word;
    logic              unused_off_bits;

    // Byte address relative to the SRAM window, reduced to a word index (wraps modulo SRAM size).
    assign byte_off        = address - 32'(BASE_ADDR);
    assign word_addr       = byte_off[ADDR_W+1:2];
    assign unused_off_bits = ^{byte_off[1:0], byte_off[31:ADDR_W+2]};

    assign last_wait = (wait_q == 4'(WAIT_CYCLES));
    assign last_word = (word_q == 2'(BURST_LEN - 1));

    // The data bus is driven only while the write strobe is low, so it is released the moment reset hits.
    assign SRAM_DQ   = we_n_q ? {DATA_W{1'bz}} : wdata_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_Addr = addr_q;
    assign rdata     = rdata_q;

    // Next-state logic for the IDLE -> ACCESS -> DONE sequence, plus ready generation.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        we_n_d  = we_n_q;
        ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = ~(wr_en | rd_en);
                if (wr_en | rd_en) begin
                    // A simultaneous read and write request is served as the write only.
                    state_d = S_ACCESS;
                    op_wr_d = wr_en;
                    addr_d  = word_addr;
                    wdata_d = wdata;
                    word_d  = 2'd0;
                    wait_d  = 4'd0;
                    we_n_d  = ~wr_en;
                end
            end
            S_ACCESS: begin
                if (!last_wait) begin
                    wait_d = wait_q + 4'd1;
                end else if (op_wr_q) begin
                    state_d = S_DONE;
                    we_n_d  = 1'b1;
                end else begin
                    for (int i = 0; i < BURST_LEN; i++) begin
                        if (word_q == 2'(i)) begin
                            rdata_d[i*DATA_W +: DATA_W] = SRAM_DQ;
                        end
                    end
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        word_d = word_q + 2'd1;
                        wait_d = 4'd0;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction and deasserts the write strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= 2'd0;
            wait_q  <= 4'd0;
            rdata_q <= '0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            we_n_q  <= we_n_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Directed bench for sram_ctrl_param: default configuration (3 wait states, 2-word burst) and a
// zero-wait single-word configuration, each with a small behavioural SRAM on its data bus.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge as well.
module tb_sram_ctrl_param;

    logic clk;
    logic rst;

    // Instance A: default parameters
    logic        wr_a, rd_a;
    logic [31:0] addr_a, wdata_a;
    logic [63:0] rdata_a;
    logic        ready_a;
    wire  [31:0] dq_a;
    logic [18:0] sa_a;
    logic        we_n_a;

    // Instance B: WAIT_CYCLES=0, BURST_LEN=1
    logic        wr_b, rd_b;
    logic [31:0] addr_b, wdata_b;
    logic [31:0] rdata_b;
    logic        ready_b;
    wire  [31:0] dq_b;
    logic [18:0] sa_b;
    logic        we_n_b;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic        sram_oe;

    int checks;
    int errors;

    sram_ctrl_param dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .address(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ready(ready_a), .SRAM_DQ(dq_a), .SRAM_Addr(sa_a), .SRAM_WE_N(we_n_a)
    );

    sram_ctrl_param #(.WAIT_CYCLES(0), .BURST_LEN(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .address(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ready(ready_b), .SRAM_DQ(dq_b), .SRAM_Addr(sa_b), .SRAM_WE_N(we_n_b)
    );

    // SRAM models drive read data whenever the write strobe is high (aliased on the low 4 address bits).
    assign dq_a = (sram_oe && we_n_a) ? mem_a[sa_a[3:0]] : 32'bz;
    assign dq_b = (sram_oe && we_n_b) ? mem_b[sa_b[3:0]] : 32'bz;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Burst read on instance A; request is presented in cycle 0 (the current half-cycle).
    task automatic read_a(input string tag, input logic [31:0] a, input logic [18:0] w0,
                          input logic [18:0] w1, input logic [63:0] exp);
        rd_a   = 1'b1;
        addr_a = a;
        #1 chk({tag, " c0 ready"}, 64'(ready_a), 64'(1'b0));
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d addr", tag, c), 64'(sa_a), 64'((c <= 4) ? w0 : w1));
            chk($sformatf("%s c%0d ready", tag, c), 64'(ready_a), 64'(1'b0));
        end
        @(negedge clk);
        chk({tag, " c9 ready"}, 64'(ready_a), 64'(1'b1));
        chk({tag, " rdata"}, rdata_a, exp);
        rd_a = 1'b0;
        @(negedge clk);
        chk({tag, " idle ready"}, 64'(ready_a), 64'(1'b1));
    endtask

    // Single write on instance A, optionally with rd_en also asserted.
    task automatic write_a(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [18:0] w, input logic also_rd);
        wr_a    = 1'b1;
        rd_a    = also_rd;
        addr_a  = a;
        wdata_a = wd;
        #1 chk({tag, " c0 ready"}, 64'(ready_a), 64'(1'b0));
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d addr", tag, c), 64'(sa_a), 64'(w));
            chk($sformatf("%s c%0d we_n", tag, c), 64'(we_n_a), 64'(1'b0));
            chk($sformatf("%s c%0d dq", tag, c), 64'(dq_a), 64'(wd));
            chk($sformatf("%s c%0d ready", tag, c), 64'(ready_a), 64'(1'b0));
        end
        @(negedge clk);
        chk({tag, " c5 ready"}, 64'(ready_a), 64'(1'b1));
        chk({tag, " c5 we_n"}, 64'(we_n_a), 64'(1'b1));
        wr_a = 1'b0;
        rd_a = 1'b0;
        @(negedge clk);
        chk({tag, " idle ready"}, 64'(ready_a), 64'(1'b1));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clk     = 1'b0;
        rst     = 1'b1;
        sram_oe = 1'b1;
        wr_a = 1'b0; rd_a = 1'b0; addr_a = '0; wdata_a = '0;
        wr_b = 1'b0; rd_b = 1'b0; addr_b = '0; wdata_b = '0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 32'hA000_0000 | 32'(i);
            mem_b[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem_a[2]  = 32'h1111_1111;
        mem_a[3]  = 32'h2222_2222;
        mem_a[15] = 32'hAAAA_0015;
        mem_a[0]  = 32'hBBBB_0000;

        // Reset values, sampled mid-reset
        #12;
        chk("rst rdata_a", rdata_a, 64'h0);
        chk("rst we_n_a", 64'(we_n_a), 64'(1'b1));
        chk("rst addr_a", 64'(sa_a), 64'h0);
        chk("rst ready_a", 64'(ready_a), 64'(1'b1));
        chk("rst dq_a model", 64'(dq_a), 64'h0000_0000_BBBB_0000);
        chk("rst rdata_b", 64'(rdata_b), 64'h0);
        chk("rst ready_b", 64'(ready_b), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Default configuration
        write_a("wr1032", 32'd1032, 32'hDEAD_BEEF, 19'd2, 1'b0);
        chk("wr keeps rdata", rdata_a, 64'h0);
        read_a("rd1032", 32'd1032, 19'd2, 19'd3, 64'h2222_2222_1111_1111);
        read_a("rdwrap", 32'd2098172, 19'h7FFFF, 19'd0, 64'hBBBB_0000_AAAA_0015);
        write_a("wr+rd", 32'd1036, 32'h1234_5678, 19'd3, 1'b1);
        chk("wr+rd no read", rdata_a, 64'hBBBB_0000_AAAA_0015);

        // Reset during cycle 2 of a write
        wr_a    = 1'b1;
        addr_a  = 32'd1040;
        wdata_a = 32'h5555_5555;
        @(negedge clk);
        @(negedge clk);
        chk("midrst pre we_n", 64'(we_n_a), 64'(1'b0));
        rst = 1'b1;
        #1;
        chk("midrst we_n", 64'(we_n_a), 64'(1'b1));
        chk("midrst addr", 64'(sa_a), 64'h0);
        chk("midrst rdata", rdata_a, 64'h0);
        chk("midrst ready req", 64'(ready_a), 64'(1'b0));
        wr_a = 1'b0;
        #1;
        chk("midrst ready idle", 64'(ready_a), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_a("rd after rst", 32'd1032, 19'd2, 19'd3, 64'h2222_2222_1111_1111);

        // Zero-wait, single-word configuration: five back-to-back reads
        rd_b   = 1'b1;
        addr_b = 32'd1024 + 32'd16;
        #1 chk("b rd0 c0 ready", 64'(ready_b), 64'(1'b0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("b rd%0d c1 addr", k), 64'(sa_b), 64'(4 + k));
            chk($sformatf("b rd%0d c1 ready", k), 64'(ready_b), 64'(1'b0));
            @(negedge clk);
            chk($sformatf("b rd%0d c2 ready", k), 64'(ready_b), 64'(1'b1));
            chk($sformatf("b rd%0d rdata", k), 64'(rdata_b), 64'(32'hC0DE_0000 | 32'(4 + k)));
            if (k < 4) begin
                addr_b = 32'd1024 + 32'(4 * (5 + k));
            end else begin
                rd_b = 1'b0;
            end
            @(negedge clk);
            if (k < 4) begin
                chk($sformatf("b rd%0d next c0 ready", k), 64'(ready_b), 64'(1'b0));
            end else begin
                chk("b idle ready", 64'(ready_b), 64'(1'b1));
            end
        end

        // Zero-wait write
        wr_b    = 1'b1;
        addr_b  = 32'd1028;
        wdata_b = 32'h0000_FACE;
        #1 chk("b wr c0 ready", 64'(ready_b), 64'(1'b0));
        @(negedge clk);
        chk("b wr c1 we_n", 64'(we_n_b), 64'(1'b0));
        chk("b wr c1 dq", 64'(dq_b), 64'h0000_FACE);
        chk("b wr c1 addr", 64'(sa_b), 64'd1);
        chk("b wr c1 ready", 64'(ready_b), 64'(1'b0));
        @(negedge clk);
        chk("b wr c2 ready", 64'(ready_b), 64'(1'b1));
        chk("b wr c2 we_n", 64'(we_n_b), 64'(1'b1));
        wr_b = 1'b0;
        @(negedge clk);
        chk("b wr keeps rdata", 64'(rdata_b), 64'h0000_0000_C0DE_0008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
